// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional zero register and a sequenced clear sweep.
// Build option: define REGFILE_BYPASS_EN for write-first same-cycle read/write forwarding.
module reg_file_mp #(
    parameter int DW       = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [AW-1:0]     w_addr,
    input  logic [DW-1:0]     w_data,
    input  logic              r_en,
    input  logic [NRD*AW-1:0] r_addr,
    output logic [NRD*DW-1:0] r_data,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [DW-1:0]     mem_q [DEPTH];
    state_t            state_q;
    logic [AW-1:0]     clr_ptr_q;
    logic              clr_busy_q;
    logic              wr_drop_q;
    logic [NRD*DW-1:0] r_data_q;
    logic [NRD*DW-1:0] r_data_d;
    logic              wr_acc_s;
    logic [AW-1:0]     rd_addr_s [NRD];

    // Addresses that always read as zero and can never be written.
    function automatic logic addr_blank(input logic [AW-1:0] a);
        logic blank;
        blank = ({1'b0, a} >= DEPTH_W);
        if ((ZERO_REG != 0) && (a == {AW{1'b0}})) begin
            blank = 1'b1;
        end else begin
            blank = blank;
        end
        return blank;
    endfunction

    // Write acceptance qualifier.
    always_comb begin
        wr_acc_s = w_en && (state_q == IDLE) && !addr_blank(w_addr);
    end

    // Unpack the flat read-address bus per port.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_addr_s[i] = r_addr[i*AW +: AW];
        end
    end

    // Sweep sequencer with registered busy and drop indications.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= {AW{1'b0}};
            clr_busy_q <= 1'b1;
            wr_drop_q  <= 1'b0;
        end else begin
            wr_drop_q <= w_en && (state_q == CLEAR);
            case (state_q)
                IDLE: begin
                    if (clr_req) begin
                        state_q    <= CLEAR;
                        clr_ptr_q  <= {AW{1'b0}};
                        clr_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_ptr_q == LAST_PTR) begin
                        state_q    <= IDLE;
                        clr_ptr_q  <= {AW{1'b0}};
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + AW'(1);
                    end
                end
                default: begin
                    state_q    <= CLEAR;
                    clr_ptr_q  <= {AW{1'b0}};
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    // Storage: the sweep owns the write port while it runs; no direct reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= {DW{1'b0}};
            end else if (wr_acc_s) begin
                mem_q[w_addr] <= w_data;
            end
        end
    end

    // Next read data per port; zero/range/sweep rules win over forwarding.
    always_comb begin
        r_data_d = r_data_q;
        if (r_en) begin
            for (int i = 0; i < NRD; i++) begin
                if ((state_q == CLEAR) || addr_blank(rd_addr_s[i])) begin
                    r_data_d[i*DW +: DW] = {DW{1'b0}};
`ifdef REGFILE_BYPASS_EN
                end else if (wr_acc_s && (w_addr == rd_addr_s[i])) begin
                    r_data_d[i*DW +: DW] = w_data;
`endif
                end else begin
                    r_data_d[i*DW +: DW] = mem_q[rd_addr_s[i]];
                end
            end
        end else begin
            r_data_d = r_data_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_q <= {(NRD*DW){1'b0}};
        end else begin
            r_data_q <= r_data_d;
        end
    end

    assign r_data   = r_data_q;
    assign clr_busy = clr_busy_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (default parameters, both bypass builds).
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic            w_en;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_data;
    logic            r_en;
    logic [2*AW-1:0] r_addr;
    logic [2*DW-1:0] r_data;
    logic            clr_req;
    logic            clr_busy;
    logic            wr_drop;

    int n_cmp = 0;
    int n_err = 0;

    reg_file_mp dut (
        .clk      (clk),
        .rst      (rst),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .r_en     (r_en),
        .r_addr   (r_addr),
        .r_data   (r_data),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .wr_drop  (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_en   = 1'b1;
        w_addr = a;
        w_data = d;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        r_en   = 1'b1;
        r_addr = {a1, a0};
        tick();
        r_en   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [DW-1:0] byp_exp;

        rst = 1'b1; w_en = 1'b0; w_addr = '0; w_data = '0;
        r_en = 1'b0; r_addr = '0; clr_req = 1'b0;
        repeat (3) tick();
        check_eq("rst_rdata", r_data, 64'h0);
        check_eq("rst_busy", clr_busy, 64'h1);
        check_eq("rst_drop", wr_drop, 64'h0);

        // Release reset: busy must last exactly 32 cycles.
        rst = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            tick();
        end
        check_eq("init_busy_len", cnt, 64'd32);

        for (int a = 0; a < 32; a += 2) begin
            do_read(AW'(a), AW'(a + 1));
            check_eq($sformatf("init_rd_%0d", a), r_data, 64'h0);
        end

        // Basic writes and two-port read.
        do_write(5'd1, 32'h0000000A);
        do_write(5'd2, 32'h0000000B);
        do_read(5'd1, 5'd2);
        check_eq("rd_portA", r_data[DW-1:0], 64'h0000000A);
        check_eq("rd_portB", r_data[2*DW-1:DW], 64'h0000000B);
        r_addr = {5'd0, 5'd0};
        tick();
        check_eq("rd_hold", r_data, 64'h0000000B_0000000A);

        // Both ports on the same address.
        do_read(5'd2, 5'd2);
        check_eq("rd_same", r_data, 64'h0000000B_0000000B);

        // Zero register ignores writes, no drop pulse.
        do_write(5'd0, 32'hDEADBEEF);
        check_eq("zero_drop", wr_drop, 64'h0);
        do_read(5'd0, 5'd1);
        check_eq("zero_rd", r_data, 64'h0000000A_00000000);
        check_eq("zero_drop2", wr_drop, 64'h0);

        // Same-cycle write and read of addr 5.
        do_write(5'd5, 32'h00000001);
        w_en = 1'b1; w_addr = 5'd5; w_data = 32'h12345678;
        r_en = 1'b1; r_addr = {5'd5, 5'd5};
        tick();
        w_en = 1'b0; r_en = 1'b0;
`ifdef REGFILE_BYPASS_EN
        byp_exp = 32'h12345678;
`else
        byp_exp = 32'h00000001;
`endif
        check_eq("byp_p0", r_data[DW-1:0], {32'h0, byp_exp});
        check_eq("byp_p1", r_data[2*DW-1:DW], {32'h0, byp_exp});
        do_read(5'd5, 5'd1);
        check_eq("byp_after", r_data, 64'h0000000A_12345678);

        // Requested sweep with a dropped write two cycles later.
        do_write(5'd3, 32'h00000033);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            w_en   = (cnt == 2);
            w_addr = 5'd3;
            w_data = 32'h000000CC;
            tick();
            if (cnt == 2) check_eq("drop_pulse", wr_drop, 64'h1);
            if (cnt == 3) check_eq("drop_end", wr_drop, 64'h0);
        end
        w_en = 1'b0;
        check_eq("req_busy_len", cnt, 64'd32);
        do_read(5'd3, 5'd1);
        check_eq("req_cleared", r_data, 64'h0);

        // Reset in mid-sweep restarts it.
        do_write(5'd20, 32'h00000055);
        do_read(5'd20, 5'd20);
        check_eq("pre_sweep_rd", r_data, 64'h00000055_00000055);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        check_eq("sweep_hold", r_data, 64'h00000055_00000055);
        check_eq("sweep_busy", clr_busy, 64'h1);
        rst = 1'b1;
        tick();
        check_eq("midrst_rdata", r_data, 64'h0);
        check_eq("midrst_busy", clr_busy, 64'h1);
        tick();
        rst = 1'b0;
        cnt = 0;
        while (clr_busy && cnt < 100) begin
            cnt++;
            r_en   = (cnt == 1);
            r_addr = {5'd20, 5'd20};
            tick();
            if (cnt == 1) check_eq("clear_rd_zero", r_data, 64'h0);
        end
        r_en = 1'b0;
        check_eq("rst_busy_len", cnt, 64'd32);

        // Top entry after sweep.
        do_write(5'd31, 32'hCAFEF00D);
        do_read(5'd31, 5'd20);
        check_eq("top_entry", r_data, 64'h00000000_CAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
